// File: rtl/apb_master_bridge.sv
`default_nettype none
// ============================================================================
// Module   : apb_master_bridge
// Purpose  : APB4 initiator turning a valid/ready command stream into single
//            APB transfers, with results returned on a valid/ready response
//            stream. Define APB_MASTER_TIMEOUT_EN to add the access timeout.
// Revision : 1.0 - initial release
// ============================================================================
module apb_master_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        pclk_i,
    input  logic        preset_i,
    // command stream
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic        cmd_write_i,
    input  logic [31:0] cmd_addr_i,
    input  logic [31:0] cmd_wdata_i,
    input  logic [3:0]  cmd_strb_i,
    // response stream
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o,
    output logic        rsp_timeout_o,
    // APB4 requester
    output logic [31:0] paddr_o,
    output logic        psel_o,
    output logic        penable_o,
    output logic        pwrite_o,
    output logic [31:0] pwdata_o,
    output logic [3:0]  pstrb_o,
    input  logic        pready_i,
    input  logic [31:0] prdata_i,
    input  logic        pslverr_i
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    state_t r_state;
    logic   w_timeout_hit;
    logic   w_access_done;
    logic   w_timeout_abort;

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int unsigned          c_CNT_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_CNT_W-1:0]   c_CNT_LIMIT = c_CNT_W'(TIMEOUT_CYCLES);

    logic [c_CNT_W-1:0] r_wait_cnt;

    // Held at zero outside ACCESS so it always starts from 0 on entry.
    always_ff @(posedge pclk_i) begin
        if (preset_i || (r_state != ST_ACCESS)) begin
            r_wait_cnt <= '0;
        end else if (!pready_i && !w_timeout_hit) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
        end
    end

    assign w_timeout_hit = (r_wait_cnt == c_CNT_LIMIT);
`else
    // TIMEOUT_CYCLES selects no logic in this build.
    if (TIMEOUT_CYCLES == 0) begin : g_timeout_param_unused
    end

    assign w_timeout_hit = 1'b0;
`endif

    // A ready responder always wins over a timeout reached in the same cycle.
    assign w_timeout_abort = w_timeout_hit && !pready_i;
    assign w_access_done   = pready_i || w_timeout_hit;

    always_ff @(posedge pclk_i) begin
        if (preset_i) begin
            r_state       <= ST_IDLE;
            cmd_ready_o   <= 1'b1;
            rsp_valid_o   <= 1'b0;
            rsp_rdata_o   <= '0;
            rsp_err_o     <= 1'b0;
            rsp_timeout_o <= 1'b0;
            paddr_o       <= '0;
            psel_o        <= 1'b0;
            penable_o     <= 1'b0;
            pwrite_o      <= 1'b0;
            pwdata_o      <= '0;
            pstrb_o       <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid_i && cmd_ready_o) begin
                        cmd_ready_o <= 1'b0;
                        if (cmd_addr_i[1:0] == 2'b00) begin
                            r_state  <= ST_SETUP;
                            psel_o   <= 1'b1;
                            paddr_o  <= cmd_addr_i;
                            pwrite_o <= cmd_write_i;
                            pwdata_o <= cmd_write_i ? cmd_wdata_i : 32'h0;
                            pstrb_o  <= cmd_write_i ? cmd_strb_i  : 4'h0;
                        end else begin
                            // Misaligned: answer at once without touching the bus.
                            r_state       <= ST_RESP;
                            rsp_valid_o   <= 1'b1;
                            rsp_err_o     <= 1'b1;
                            rsp_timeout_o <= 1'b0;
                            rsp_rdata_o   <= '0;
                        end
                    end
                end

                ST_SETUP: begin
                    r_state   <= ST_ACCESS;
                    penable_o <= 1'b1;
                end

                ST_ACCESS: begin
                    if (w_access_done) begin
                        r_state       <= ST_RESP;
                        rsp_valid_o   <= 1'b1;
                        rsp_err_o     <= w_timeout_abort ? 1'b1 : pslverr_i;
                        rsp_timeout_o <= w_timeout_abort;
                        rsp_rdata_o   <= (pready_i && !pwrite_o && !pslverr_i) ? prdata_i : 32'h0;
                        psel_o        <= 1'b0;
                        penable_o     <= 1'b0;
                        paddr_o       <= '0;
                        pwrite_o      <= 1'b0;
                        pwdata_o      <= '0;
                        pstrb_o       <= '0;
                    end
                end

                ST_RESP: begin
                    if (rsp_ready_i) begin
                        r_state       <= ST_IDLE;
                        cmd_ready_o   <= 1'b1;
                        rsp_valid_o   <= 1'b0;
                        rsp_err_o     <= 1'b0;
                        rsp_timeout_o <= 1'b0;
                        rsp_rdata_o   <= '0;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_apb_master_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb_master_bridge
// Purpose  : Self-checking bench for apb_master_bridge against a transaction
//            level model of latency and response contents.
// Revision : 1.0 - initial release
// ============================================================================
module tb_apb_master_bridge;

    localparam int unsigned c_TB_TIMEOUT = 8;

    logic        pclk_i = 1'b0;
    logic        preset_i = 1'b1;
    logic        cmd_valid_i = 1'b0;
    logic        cmd_ready_o;
    logic        cmd_write_i = 1'b0;
    logic [31:0] cmd_addr_i = '0;
    logic [31:0] cmd_wdata_i = '0;
    logic [3:0]  cmd_strb_i = '0;
    logic        rsp_valid_o;
    logic        rsp_ready_i = 1'b0;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;
    logic        rsp_timeout_o;
    logic [31:0] paddr_o;
    logic        psel_o;
    logic        penable_o;
    logic        pwrite_o;
    logic [31:0] pwdata_o;
    logic [3:0]  pstrb_o;
    logic        pready_i = 1'b0;
    logic [31:0] prdata_i = '0;
    logic        pslverr_i = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 pclk_i = ~pclk_i;

    apb_master_bridge #(
        .TIMEOUT_CYCLES(c_TB_TIMEOUT)
    ) u_dut (
        .pclk_i        (pclk_i),
        .preset_i      (preset_i),
        .cmd_valid_i   (cmd_valid_i),
        .cmd_ready_o   (cmd_ready_o),
        .cmd_write_i   (cmd_write_i),
        .cmd_addr_i    (cmd_addr_i),
        .cmd_wdata_i   (cmd_wdata_i),
        .cmd_strb_i    (cmd_strb_i),
        .rsp_valid_o   (rsp_valid_o),
        .rsp_ready_i   (rsp_ready_i),
        .rsp_rdata_o   (rsp_rdata_o),
        .rsp_err_o     (rsp_err_o),
        .rsp_timeout_o (rsp_timeout_o),
        .paddr_o       (paddr_o),
        .psel_o        (psel_o),
        .penable_o     (penable_o),
        .pwrite_o      (pwrite_o),
        .pwdata_o      (pwdata_o),
        .pstrb_o       (pstrb_o),
        .pready_i      (pready_i),
        .prdata_i      (prdata_i),
        .pslverr_i     (pslverr_i)
    );

    task automatic step();
        @(posedge pclk_i);
        #1;
    endtask

    // Present one command, act as the responder with a given wait count,
    // then hold the response for rsp_hold cycles before consuming it.
    task automatic do_txn(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] strb, input int waits, input bit slverr,
                          input logic [31:0] rd, input int rsp_hold, input string tag);
        bit           mis;
        logic [31:0]  exp_rdata;
        bit           exp_err;
        logic [68:0]  exp_apb;
        logic [106:0] exp_rsp;
        mis       = (addr % 4) != 0;
        exp_err   = mis || slverr;
        exp_rdata = (mis || wr || slverr) ? 32'h0 : rd;
        exp_apb   = {addr, wr, (wr ? wdata : 32'h0), (wr ? strb : 4'h0)};
        exp_rsp   = {1'b1, exp_err, 1'b0, exp_rdata, 1'b0, 1'b0, 1'b0, 69'h0};

        cmd_valid_i = 1'b1;
        cmd_write_i = wr;
        cmd_addr_i  = addr;
        cmd_wdata_i = wdata;
        cmd_strb_i  = strb;
        n_checks++;
        if (cmd_ready_o !== 1'b1)
            $display("FAIL %s cmd_ready actual=%b required=1", tag, cmd_ready_o);
        else
            n_pass++;
        step();
        cmd_valid_i = 1'b0;
        cmd_write_i = 1'($urandom);
        cmd_addr_i  = $urandom;
        cmd_wdata_i = $urandom;
        cmd_strb_i  = 4'($urandom);

        if (!mis) begin
            // c==0 is the setup cycle, c>=1 are access cycles
            for (int c = 0; c < waits + 2; c++) begin
                n_checks++;
                if ({psel_o, penable_o, rsp_valid_o, cmd_ready_o, paddr_o, pwrite_o, pwdata_o, pstrb_o}
                    !== {1'b1, (c != 0), 1'b0, 1'b0, exp_apb})
                    $display("FAIL %s apb_phase%0d actual=%h required=%h", tag, c,
                             {psel_o, penable_o, rsp_valid_o, cmd_ready_o, paddr_o, pwrite_o, pwdata_o, pstrb_o},
                             {1'b1, (c != 0), 1'b0, 1'b0, exp_apb});
                else
                    n_pass++;
                if (c >= 1) begin
                    pready_i  = (c - 1 == waits);
                    pslverr_i = (c - 1 == waits) ? slverr : 1'($urandom);
                    prdata_i  = (c - 1 == waits) ? rd : $urandom;
                end
                step();
            end
            pready_i  = 1'b0;
            pslverr_i = 1'b0;
            prdata_i  = $urandom;
        end

        n_checks++;
        if ({rsp_valid_o, rsp_err_o, rsp_timeout_o, rsp_rdata_o, psel_o, penable_o, cmd_ready_o,
             paddr_o, pwrite_o, pwdata_o, pstrb_o} !== exp_rsp)
            $display("FAIL %s response actual=%h required=%h", tag,
                     {rsp_valid_o, rsp_err_o, rsp_timeout_o, rsp_rdata_o, psel_o, penable_o, cmd_ready_o,
                      paddr_o, pwrite_o, pwdata_o, pstrb_o}, exp_rsp);
        else
            n_pass++;

        for (int h = 0; h < rsp_hold; h++) begin
            rsp_ready_i = 1'b0;
            step();
            n_checks++;
            if ({rsp_valid_o, rsp_err_o, rsp_timeout_o, rsp_rdata_o, cmd_ready_o, psel_o}
                !== {1'b1, exp_err, 1'b0, exp_rdata, 1'b0, 1'b0})
                $display("FAIL %s rsp_hold%0d actual=%h required=%h", tag, h,
                         {rsp_valid_o, rsp_err_o, rsp_timeout_o, rsp_rdata_o, cmd_ready_o, psel_o},
                         {1'b1, exp_err, 1'b0, exp_rdata, 1'b0, 1'b0});
            else
                n_pass++;
        end
        rsp_ready_i = 1'b1;
        step();
        rsp_ready_i = 1'b0;
        n_checks++;
        if ({rsp_valid_o, cmd_ready_o, psel_o} !== 3'b010)
            $display("FAIL %s after_handshake actual=%b required=010", tag,
                     {rsp_valid_o, cmd_ready_o, psel_o});
        else
            n_pass++;
    endtask

    task automatic test_reset();
        logic [106:0] exp_rst;
        exp_rst = {1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0};
        preset_i = 1'b1;
        step();
        step();
        n_checks++;
        if ({cmd_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o, paddr_o, psel_o,
             penable_o, pwrite_o, pwdata_o, pstrb_o} !== exp_rst)
            $display("FAIL reset_values actual=%h required=%h",
                     {cmd_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o, paddr_o, psel_o,
                      penable_o, pwrite_o, pwdata_o, pstrb_o}, exp_rst);
        else
            n_pass++;
        preset_i = 1'b0;
        step();
    endtask

    task automatic test_zero_wait_write();
        do_txn(1'b1, 32'h0, 32'h0001_1052, 4'hF, 0, 1'b0, 32'h1234_5678, 0, "zero_wait_write");
    endtask

    task automatic test_read_wait();
        do_txn(1'b0, 32'h8, 32'hFFFF_FFFF, 4'hF, 3, 1'b0, 32'h0001_1100, 0, "read_3wait");
    endtask

    task automatic test_slave_error();
        do_txn(1'b1, 32'hC, 32'hA5A5_A5A5, 4'h3, 1, 1'b1, 32'h0, 0, "slverr_write");
        do_txn(1'b0, 32'h4, 32'h0, 4'h0, 0, 1'b1, 32'hDEAD_BEEF, 0, "slverr_read");
    endtask

    task automatic test_misaligned();
        do_txn(1'b0, 32'h6, 32'h0, 4'h0, 0, 1'b0, 32'h0, 0, "misaligned_read");
        do_txn(1'b1, 32'h101, 32'h55AA_55AA, 4'hF, 0, 1'b0, 32'h0, 1, "misaligned_write");
    endtask

    task automatic test_backpressure();
        do_txn(1'b0, 32'h20, 32'h0, 4'h0, 2, 1'b0, 32'hCAFE_0001, 5, "backpressure");
    endtask

    task automatic test_timeout();
`ifdef APB_MASTER_TIMEOUT_EN
        cmd_valid_i = 1'b1;
        cmd_write_i = 1'b0;
        cmd_addr_i  = 32'h10;
        step();
        cmd_valid_i = 1'b0;
        // setup plus TIMEOUT+1 access cycles (counter values 0..TIMEOUT)
        for (int c = 0; c < int'(c_TB_TIMEOUT) + 2; c++) begin
            n_checks++;
            if ({psel_o, penable_o, rsp_valid_o} !== {1'b1, (c != 0), 1'b0})
                $display("FAIL timeout_wait%0d actual=%b required=%b", c,
                         {psel_o, penable_o, rsp_valid_o}, {1'b1, (c != 0), 1'b0});
            else
                n_pass++;
            pready_i = 1'b0;
            prdata_i = $urandom;
            step();
        end
        n_checks++;
        if ({rsp_valid_o, rsp_err_o, rsp_timeout_o, rsp_rdata_o, psel_o, penable_o}
            !== {1'b1, 1'b1, 1'b1, 32'h0, 1'b0, 1'b0})
            $display("FAIL timeout_abort actual=%h required=%h",
                     {rsp_valid_o, rsp_err_o, rsp_timeout_o, rsp_rdata_o, psel_o, penable_o},
                     {1'b1, 1'b1, 1'b1, 32'h0, 1'b0, 1'b0});
        else
            n_pass++;
        rsp_ready_i = 1'b1;
        step();
        rsp_ready_i = 1'b0;
        // ready arriving exactly at the limit completes normally
        do_txn(1'b0, 32'h14, 32'h0, 4'h0, int'(c_TB_TIMEOUT), 1'b0, 32'h0BAD_F00D, 0, "ready_at_limit");
`else
        int early;
        early = 0;
        cmd_valid_i = 1'b1;
        cmd_write_i = 1'b0;
        cmd_addr_i  = 32'h10;
        step();
        cmd_valid_i = 1'b0;
        for (int c = 0; c < 1000; c++) begin
            if (rsp_valid_o !== 1'b0 || (c > 0 && {psel_o, penable_o} !== 2'b11))
                early++;
            pready_i = 1'b0;
            step();
        end
        n_checks++;
        if (early != 0)
            $display("FAIL no_timeout_wait bad_cycles=%0d required=0", early);
        else
            n_pass++;
        pready_i = 1'b1;
        prdata_i = 32'h7777_0001;
        step();
        pready_i = 1'b0;
        n_checks++;
        if ({rsp_valid_o, rsp_err_o, rsp_timeout_o, rsp_rdata_o} !== {1'b1, 1'b0, 1'b0, 32'h7777_0001})
            $display("FAIL late_ready_complete actual=%h required=%h",
                     {rsp_valid_o, rsp_err_o, rsp_timeout_o, rsp_rdata_o},
                     {1'b1, 1'b0, 1'b0, 32'h7777_0001});
        else
            n_pass++;
        rsp_ready_i = 1'b1;
        step();
        rsp_ready_i = 1'b0;
`endif
    endtask

    task automatic test_reset_mid_access();
        int stray;
        stray = 0;
        cmd_valid_i = 1'b1;
        cmd_write_i = 1'b1;
        cmd_addr_i  = 32'h30;
        cmd_wdata_i = 32'h1111_2222;
        cmd_strb_i  = 4'hF;
        step();
        cmd_valid_i = 1'b0;
        step();
        step();
        preset_i = 1'b1;
        step();
        preset_i = 1'b0;
        n_checks++;
        if ({psel_o, penable_o, rsp_valid_o, cmd_ready_o, paddr_o, pwdata_o, pstrb_o, pwrite_o}
            !== {4'b0001, 32'h0, 32'h0, 4'h0, 1'b0})
            $display("FAIL reset_mid_access actual=%h required=%h",
                     {psel_o, penable_o, rsp_valid_o, cmd_ready_o, paddr_o, pwdata_o, pstrb_o, pwrite_o},
                     {4'b0001, 32'h0, 32'h0, 4'h0, 1'b0});
        else
            n_pass++;
        pready_i = 1'b1;
        for (int c = 0; c < 20; c++) begin
            step();
            if (rsp_valid_o !== 1'b0 || psel_o !== 1'b0) stray++;
        end
        pready_i = 1'b0;
        n_checks++;
        if (stray != 0)
            $display("FAIL reset_discard stray_cycles=%0d required=0", stray);
        else
            n_pass++;
    endtask

    task automatic test_back_to_back();
        do_txn(1'b1, 32'h40, 32'h0000_00AA, 4'h1, 0, 1'b0, 32'h0, 0, "b2b_0");
        do_txn(1'b0, 32'h44, 32'h0, 4'h0, 0, 1'b0, 32'h4444_0044, 0, "b2b_1");
        do_txn(1'b0, 32'h47, 32'h0, 4'h0, 0, 1'b0, 32'h0, 0, "b2b_2");
        do_txn(1'b1, 32'h48, 32'h8888_0048, 4'hC, 1, 1'b0, 32'h0, 0, "b2b_3");
    endtask

    task automatic test_random();
        logic [31:0] addr;
        for (int i = 0; i < 24; i++) begin
            addr = $urandom;
            if ($urandom_range(0, 3) != 0) addr[1:0] = 2'b00;
            do_txn(1'($urandom_range(0, 1)), addr, $urandom, 4'($urandom), int'($urandom_range(0, 4)),
                   ($urandom_range(0, 3) == 0), $urandom, int'($urandom_range(0, 3)), "random");
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired before summary");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_zero_wait_write();
        test_read_wait();
        test_slave_error();
        test_misaligned();
        test_backpressure();
        test_timeout();
        test_reset_mid_access();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
